// File: rtl/fpu_sched_pkg.sv
// Shared types and helpers for the FPU issue scheduler: op encoding, queue entry, read/write sets.
// The FPU_PRECISION_CHECK_EN build uses needs_prec() to pick which ops are precision checked.
package fpu_sched_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_LD  = 3'd4,
        OP_SD  = 3'd5,
        OP_CMP = 3'd6
    } op_t;

    typedef struct packed {
        op_t        op;
        logic       dbl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [8:0] imm;
    } entry_t;

    function automatic int op_lat(input op_t op, input int add_lat, input int mul_lat,
                                  input int ld_lat);
        case (op)
            OP_ADD, OP_SUB: return add_lat;
            OP_MUL:         return mul_lat;
            OP_LD:          return ld_lat;
            default:        return 0;
        endcase
    endfunction

    function automatic logic reads_rs1(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_CMP) || (op == OP_SD);
    endfunction

    function automatic logic reads_rs2(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_CMP);
    endfunction

    function automatic logic writes_rd(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_LD);
    endfunction

    function automatic logic is_real_op(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_LD) ||
               (op == OP_SD)  || (op == OP_CMP);
    endfunction

    function automatic logic needs_prec(input op_t op);
        return reads_rs2(op);
    endfunction

endpackage

// File: rtl/fpu_sched_fifo.sv
// Instruction queue for the FPU issue scheduler: DEPTH entries, single-edge flush.
// A full queue refuses a push even while popping; flush wins over push and pop.
module fpu_sched_fifo
    import fpu_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_sched.sv
// In-order FPU issue scheduler: queue, scoreboard, writeback-slot shift register.
// Optional FPU_PRECISION_CHECK_EN adds a precision map that drops mixed-precision ops (inv_flag).
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ADD_LAT = 4,
    parameter int MUL_LAT = 5,
    parameter int LD_LAT  = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_dbl,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [8:0]       in_imm,
    input  logic             flush,
    output logic             iss_valid,
    output logic [2:0]       iss_op,
    output logic             iss_dbl,
    output logic [4:0]       iss_rd,
    output logic [4:0]       iss_rs1,
    output logic [4:0]       iss_rs2,
    output logic [8:0]       iss_imm,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_dbl,
    output logic [31:0]      busy_map,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             idle
`ifdef FPU_PRECISION_CHECK_EN
    ,
    output logic             inv_flag
`endif
);

    entry_t       in_entry;
    entry_t       head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         head_valid;
    logic         pop;

    logic [MUL_LAT-1:0] slot_v;
    logic [4:0]         slot_rd  [MUL_LAT];
    logic               slot_dbl [MUL_LAT];

    logic [31:0]  clr_mask;
    logic [31:0]  fwd_mask;
    logic [31:0]  eff_busy;
    int           lat;
    logic         raw;
    logic         waw;
    logic         collide;
    logic         ready;
    logic         drop;
    logic         issue;
    logic         issue_wr;
    logic         alive;

    assign in_entry = '{op: op_t'(in_op), dbl: in_dbl, rd: in_rd, rs1: in_rs1,
                        rs2: in_rs2, imm: in_imm};
    assign in_ready   = !fifo_full;
    assign head_valid = !fifo_empty;

    fpu_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .flush (flush),
        .din   (in_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // busy_map sets one edge after issue, so the op in iss_* is forwarded; the register
    // being written back this cycle is already treated as free.
    always_comb begin
        clr_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
        fwd_mask = (iss_valid && writes_rd(op_t'(iss_op))) ? (32'd1 << iss_rd) : 32'd0;
        eff_busy = (busy_map & ~clr_mask) | fwd_mask;
        lat      = op_lat(head.op, ADD_LAT, MUL_LAT, LD_LAT);
        raw      = (reads_rs1(head.op) && eff_busy[head.rs1]) ||
                   (reads_rs2(head.op) && eff_busy[head.rs2]);
        waw      = writes_rd(head.op) && eff_busy[head.rd];
        collide  = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            if (writes_rd(head.op) && (i == lat) && slot_v[i]) begin
                collide = 1'b1;
            end
        end
        ready    = head_valid && !flush && !raw && !waw && !collide;
        issue    = ready && !drop && is_real_op(head.op);
        issue_wr = issue && writes_rd(head.op);
        pop      = ready;
    end

`ifdef FPU_PRECISION_CHECK_EN
    logic [31:0] prec_map;
    logic [31:0] eff_prec;
    logic        mismatch;

    always_comb begin
        eff_prec = prec_map;
        if (wb_valid) begin
            eff_prec[wb_rd] = wb_dbl;
        end
        mismatch = needs_prec(head.op) &&
                   ((eff_prec[head.rs1] != head.dbl) || (eff_prec[head.rs2] != head.dbl));
        drop     = ready && mismatch;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prec_map <= '0;
            inv_flag <= 1'b0;
        end else begin
            if (wb_valid) begin
                prec_map[wb_rd] <= wb_dbl;
            end
            if (drop) begin
                inv_flag <= 1'b1;
            end
        end
    end
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid <= 1'b0;
            iss_op    <= '0;
            iss_dbl   <= 1'b0;
            iss_rd    <= '0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_imm   <= '0;
            slot_v    <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                slot_rd[i]  <= '0;
                slot_dbl[i] <= 1'b0;
            end
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_dbl    <= 1'b0;
            busy_map  <= '0;
            stall_cnt <= '0;
            alive     <= 1'b0;
        end else begin
            alive     <= 1'b1;
            iss_valid <= issue;
            if (issue) begin
                iss_op  <= head.op;
                iss_dbl <= head.dbl;
                iss_rd  <= head.rd;
                iss_rs1 <= head.rs1;
                iss_rs2 <= head.rs2;
                iss_imm <= head.imm;
            end
            // Slot i drains into wb_* after i+1 more edges, so a writer lands at LAT-1.
            for (int i = 0; i < MUL_LAT - 1; i++) begin
                slot_v[i]   <= slot_v[i+1];
                slot_rd[i]  <= slot_rd[i+1];
                slot_dbl[i] <= slot_dbl[i+1];
            end
            slot_v[MUL_LAT-1]   <= 1'b0;
            slot_rd[MUL_LAT-1]  <= '0;
            slot_dbl[MUL_LAT-1] <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) begin
                if (issue_wr && (i == lat - 1)) begin
                    slot_v[i]   <= 1'b1;
                    slot_rd[i]  <= head.rd;
                    slot_dbl[i] <= head.dbl;
                end
            end
            wb_valid <= slot_v[0];
            wb_rd    <= slot_rd[0];
            wb_dbl   <= slot_dbl[0];
            busy_map <= eff_busy;
            if (head_valid && !pop && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign idle = alive && fifo_empty && (busy_map == '0) && (slot_v == '0) &&
                  !wb_valid && !iss_valid;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched: hazards, slot collisions, full queue, flush, reset.
// With FPU_PRECISION_CHECK_EN defined it also covers the mixed-precision drop and inv_flag.
module tb_fpu_issue_sched;

    localparam logic [2:0] ADD = 3'd1;
    localparam logic [2:0] MUL = 3'd3;
    localparam logic [2:0] LD  = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic        in_dbl = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [8:0]  in_imm = '0;
    logic        flush = 1'b0;
    logic        iss_valid;
    logic [2:0]  iss_op;
    logic        iss_dbl;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [8:0]  iss_imm;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_dbl;
    logic [31:0] busy_map;
    logic [15:0] stall_cnt;
    logic        idle;
`ifdef FPU_PRECISION_CHECK_EN
    logic        inv_flag;
`endif

    fpu_issue_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_dbl    (in_dbl),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_op    (iss_op),
        .iss_dbl   (iss_dbl),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_imm   (iss_imm),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_dbl    (wb_dbl),
        .busy_map  (busy_map),
        .stall_cnt (stall_cnt),
        .idle      (idle)
`ifdef FPU_PRECISION_CHECK_EN
        ,
        .inv_flag  (inv_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [4:0] rd;
        logic       dbl;
    } ev_t;

    ev_t iss_q[$];
    ev_t wb_q[$];

    always @(negedge clk) begin
        if (rst) begin
            if (iss_valid) iss_q.push_back('{c: cyc, rd: iss_rd, dbl: iss_dbl});
            if (wb_valid)  wb_q.push_back('{c: cyc, rd: wb_rd, dbl: wb_dbl});
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        iss_q.delete();
        wb_q.delete();
    endtask

    task automatic push(input logic [2:0] op, input logic dbl, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, output int pc);
        in_op    = op;
        in_dbl   = dbl;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = 9'(rd);
        in_valid = 1'b1;
        step(1);
        pc       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        step(3);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_chk++; if (busy_map !== 32'h0) begin n_fail++; $display("FAIL reset_busy_map: got %h want 0", busy_map); end
        n_chk++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", idle); end
        rst = 1'b1;
        step(2);
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got %b want 1", idle); end
    endtask

    task automatic test_single_add();
        int pc, c;
        logic exp_iss, exp_wb, exp_busy;
        do_reset();
        push(ADD, 1'b0, 5'd3, 5'd1, 5'd2, pc);
        c = pc + 1;
        for (int k = 0; k < 7; k++) begin
            exp_iss  = (cyc == c);
            exp_wb   = (cyc == c + 4);
            exp_busy = (cyc >= c + 1) && (cyc <= c + 4);
            n_chk++; if (iss_valid !== exp_iss) begin n_fail++; $display("FAIL add_iss_valid at c+%0d: got %b want %b", cyc - c, iss_valid, exp_iss); end
            n_chk++; if (wb_valid !== exp_wb) begin n_fail++; $display("FAIL add_wb_valid at c+%0d: got %b want %b", cyc - c, wb_valid, exp_wb); end
            n_chk++; if (busy_map[3] !== exp_busy) begin n_fail++; $display("FAIL add_busy3 at c+%0d: got %b want %b", cyc - c, busy_map[3], exp_busy); end
            if (exp_wb) begin
                n_chk++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL add_wb_rd: got %0d want 3", wb_rd); end
            end
            step(1);
        end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL add_stall_cnt: got %0d want 0", stall_cnt); end
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL add_idle: got %b want 1", idle); end
    endtask

    task automatic test_raw();
        int p1, p2, c;
        do_reset();
        push(ADD, 1'b0, 5'd3, 5'd1, 5'd2, p1);
        push(MUL, 1'b0, 5'd4, 5'd3, 5'd1, p2);
        step(14);
        n_chk++; if (iss_q.size() != 2) begin n_fail++; $display("FAIL raw_iss_count: got %0d want 2", iss_q.size()); end
        n_chk++; if (wb_q.size() != 2) begin n_fail++; $display("FAIL raw_wb_count: got %0d want 2", wb_q.size()); end
        if (iss_q.size() == 2 && wb_q.size() == 2) begin
            c = iss_q[0].c;
            n_chk++; if (c != p1 + 1) begin n_fail++; $display("FAIL raw_add_issue_cycle: got push+%0d want push+1", c - p1); end
            n_chk++; if (iss_q[1].c - c != 5) begin n_fail++; $display("FAIL raw_mul_issue: got c+%0d want c+5", iss_q[1].c - c); end
            n_chk++; if (wb_q[0].c - c != 4 || wb_q[0].rd != 5'd3) begin n_fail++; $display("FAIL raw_add_wb: got c+%0d rd %0d want c+4 rd 3", wb_q[0].c - c, wb_q[0].rd); end
            n_chk++; if (wb_q[1].c - c != 10 || wb_q[1].rd != 5'd4) begin n_fail++; $display("FAIL raw_mul_wb: got c+%0d rd %0d want c+10 rd 4", wb_q[1].c - c, wb_q[1].rd); end
        end
        n_chk++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_collision();
        int p1, p2, c;
        do_reset();
        push(MUL, 1'b1, 5'd5, 5'd1, 5'd2, p1);
        push(ADD, 1'b0, 5'd6, 5'd1, 5'd2, p2);
        step(12);
        n_chk++; if (iss_q.size() != 2 || wb_q.size() != 2) begin n_fail++; $display("FAIL coll_counts: got iss %0d wb %0d want 2 2", iss_q.size(), wb_q.size()); end
        if (iss_q.size() == 2 && wb_q.size() == 2) begin
            c = iss_q[0].c;
            n_chk++; if (iss_q[1].c - c != 2) begin n_fail++; $display("FAIL coll_add_issue: got c+%0d want c+2", iss_q[1].c - c); end
            n_chk++; if (wb_q[0].c - c != 5 || wb_q[0].rd != 5'd5 || wb_q[0].dbl != 1'b1) begin n_fail++; $display("FAIL coll_mul_wb: got c+%0d rd %0d dbl %b want c+5 rd 5 dbl 1", wb_q[0].c - c, wb_q[0].rd, wb_q[0].dbl); end
            n_chk++; if (wb_q[1].c - c != 6 || wb_q[1].rd != 5'd6) begin n_fail++; $display("FAIL coll_add_wb: got c+%0d rd %0d want c+6 rd 6", wb_q[1].c - c, wb_q[1].rd); end
        end
        n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL coll_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    // Chain of MUL r1=r1*r1: pops at edges 2, 8, 14, so the queue fills at edge 10.
    task automatic test_full();
        logic exp_ready;
        do_reset();
        in_op    = MUL;
        in_dbl   = 1'b0;
        in_rd    = 5'd1;
        in_rs1   = 5'd1;
        in_rs2   = 5'd1;
        in_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            exp_ready = !(k >= 10 && k <= 13);
            n_chk++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL full_in_ready after edge %0d: got %b want %b", k, in_ready, exp_ready); end
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step(1);
        flush = 1'b0;
        step(12);
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_drain_idle: got %b want 1", idle); end
    endtask

    task automatic test_flush();
        int p1, p2;
        do_reset();
        push(MUL, 1'b0, 5'd7, 5'd1, 5'd2, p1);
        push(ADD, 1'b0, 5'd8, 5'd7, 5'd7, p2);
        push(ADD, 1'b0, 5'd8, 5'd7, 5'd7, p2);
        push(ADD, 1'b0, 5'd8, 5'd7, 5'd7, p2);
        in_op    = ADD;
        in_rd    = 5'd9;
        in_rs1   = 5'd1;
        in_rs2   = 5'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        step(1);
        in_valid = 1'b0;
        flush    = 1'b0;
        step(12);
        n_chk++; if (iss_q.size() != 1) begin n_fail++; $display("FAIL flush_iss_count: got %0d want 1", iss_q.size()); end
        n_chk++; if (wb_q.size() != 1) begin n_fail++; $display("FAIL flush_wb_count: got %0d want 1", wb_q.size()); end
        if (iss_q.size() == 1 && wb_q.size() == 1) begin
            n_chk++; if (wb_q[0].c - iss_q[0].c != 5 || wb_q[0].rd != 5'd7) begin n_fail++; $display("FAIL flush_mul_wb: got c+%0d rd %0d want c+5 rd 7", wb_q[0].c - iss_q[0].c, wb_q[0].rd); end
        end
        n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d want 3", stall_cnt); end
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %b want 1", idle); end
    endtask

    task automatic test_reset_mid();
        int p1;
        do_reset();
        push(MUL, 1'b0, 5'd9, 5'd1, 5'd2, p1);
        step(2);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        n_chk++; if (busy_map !== 32'h0) begin n_fail++; $display("FAIL midrst_busy_map: got %h want 0", busy_map); end
        step(10);
        n_chk++; if (wb_q.size() != 0) begin n_fail++; $display("FAIL midrst_wb_count: got %0d want 0", wb_q.size()); end
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b want 1", idle); end
    endtask

    task automatic test_precision();
        int pc;
        do_reset();
        push(LD,  1'b1, 5'd1, 5'd0, 5'd0, pc);
        push(LD,  1'b0, 5'd2, 5'd0, 5'd0, pc);
        push(ADD, 1'b0, 5'd3, 5'd1, 5'd2, pc);
        push(ADD, 1'b0, 5'd4, 5'd2, 5'd2, pc);
        step(12);
`ifdef FPU_PRECISION_CHECK_EN
        n_chk++; if (iss_q.size() != 3) begin n_fail++; $display("FAIL prec_iss_count: got %0d want 3", iss_q.size()); end
        if (iss_q.size() == 3) begin
            n_chk++; if (iss_q[2].rd != 5'd4) begin n_fail++; $display("FAIL prec_third_rd: got %0d want 4", iss_q[2].rd); end
        end
        n_chk++; if (inv_flag !== 1'b1) begin n_fail++; $display("FAIL prec_inv_flag: got %b want 1", inv_flag); end
`else
        n_chk++; if (iss_q.size() != 4) begin n_fail++; $display("FAIL prec_iss_count: got %0d want 4", iss_q.size()); end
        if (iss_q.size() == 4) begin
            n_chk++; if (iss_q[2].rd != 5'd3) begin n_fail++; $display("FAIL prec_third_rd: got %0d want 3", iss_q[2].rd); end
        end
`endif
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL prec_idle: got %b want 1", idle); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_raw();
        test_collision();
        test_full();
        test_flush();
        test_reset_mid();
        test_precision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
